// File: rtl/cardinal_nic.sv
// Cardinal network interface controller.
// Two one-entry buffers sit between a memory-mapped processor port and a router port:
// - The input buffer receives packets from the router; the processor reads them.
// - The output buffer is written by the processor and sent to the router.
// Buffers use [0:DATA_WIDTH-1] ordering. Bit 0, the MSB, is the virtual-channel (VC) bit.
module cardinal_nic #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [1:0] ADDR_IB     = 2'b00;
    localparam logic [1:0] ADDR_IB_STS = 2'b01;
    localparam logic [1:0] ADDR_OB     = 2'b10;
    localparam logic [1:0] ADDR_OB_STS = 2'b11;

    logic [0:DW-1] ib;
    logic [0:DW-1] ob;
    logic          ib_full;
    logic          ob_full;

    logic          ob_load;
    logic          ib_consume;
    logic          ib_capture;

    // Handshake qualifiers. Each one uses the buffer flags as they stand before the edge.
    // The processor write and the transmit are mutually exclusive: the write needs
    // ob_full=0 and the transmit needs ob_full=1. The consume and the capture are
    // exclusive in the same way through ib_full.
    always_comb begin
        ob_load    = nicEn & nicWrEn & (addr == ADDR_OB) & ~ob_full;
        ib_consume = nicEn & ~nicWrEn & (addr == ADDR_IB) & ib_full;
        ib_capture = net_si & ~ib_full;
    end

    // Router-side outputs. A packet leaves only when its VC bit matches the router phase.
    always_comb begin
        net_ri = ~ib_full;
        net_so = ob_full & net_ro & (ob[0] == net_polarity);
        net_do = ob;
    end

    // Processor read mux. Status flags sit in the last bit position, which is the LSB.
    always_comb begin
        d_out = '0;
        case (addr)
            ADDR_IB:     d_out = ib;
            ADDR_IB_STS: d_out[DW-1] = ib_full;
            ADDR_OB_STS: d_out[DW-1] = ob_full;
            default:     d_out = '0;
        endcase
    end

    // Input buffer. The router fills it, and a processor read at ADDR_IB frees it.
    // The data is left in place so that later reads return the stale packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ib      <= '0;
            ib_full <= 1'b0;
        end else if (ib_capture) begin
            ib      <= net_di;
            ib_full <= 1'b1;
        end else if (ib_consume) begin
            ib_full <= 1'b0;
        end
    end

    // Output buffer. The processor fills it, and a router handshake drains it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ob      <= '0;
            ob_full <= 1'b0;
        end else if (net_so) begin
            ob_full <= 1'b0;
        end else if (ob_load) begin
            ob      <= d_in;
            ob_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic.
// Inputs are driven 1 time unit after each rising edge; outputs are checked before the next edge.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        nicEn;
    logic        nicWrEn;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;

    cardinal_nic #(.DATA_WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .d_in         (d_in),
        .d_out        (d_out),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select a register address and let the combinational read path settle.
    task automatic peek(input logic [1:0] a);
        addr = a;
        #1;
    endtask

    initial begin
        reset = 1'b0; addr = 2'b00; nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

        // Outputs while reset is held
        #2;
        check("rst_net_ri", 64'(net_ri), 64'd1);
        check("rst_net_so", 64'(net_so), 64'd0);
        check("rst_net_do", net_do, 64'd0);
        for (int a = 0; a < 4; a++) begin
            peek(2'(a));
            check("rst_d_out", d_out, 64'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Send path with matching polarity
        net_polarity = 1'b1; net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_00A5;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        peek(2'b11);
        check("send_so", 64'(net_so), 64'd1);
        check("send_do", net_do, 64'h8000_0000_0000_00A5);
        check("send_ob_full", d_out, 64'd1);
        tick();
        check("send_so_clr", 64'(net_so), 64'd0);
        check("send_ob_full_clr", d_out, 64'd0);
        peek(2'b10);
        check("ob_read_zero", d_out, 64'd0);

        // Polarity hold: the VC bit is 1 while the router phase is 0
        net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_0001;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        peek(2'b11);
        for (int i = 0; i < 5; i++) begin
            check("hold_so", 64'(net_so), 64'd0);
            check("hold_ob_full", d_out, 64'd1);
            tick();
        end
        net_polarity = 1'b1;
        #1;
        check("hold_release_so", 64'(net_so), 64'd1);
        check("hold_release_do", net_do, 64'h8000_0000_0000_0001);
        tick();
        check("hold_after_so", 64'(net_so), 64'd0);
        check("hold_after_full", d_out, 64'd0);

        // Receive path; a second packet stays with the router while the buffer is full
        net_si = 1'b1; net_di = 64'h1234;
        tick();
        net_di = 64'h5678;
        peek(2'b01);
        check("rx_ri", 64'(net_ri), 64'd0);
        check("rx_ib_full", d_out, 64'd1);
        tick();
        peek(2'b00);
        check("rx_held_ib", d_out, 64'h1234);
        nicEn = 1'b1; nicWrEn = 1'b0;
        #1;
        check("rx_read_data", d_out, 64'h1234);
        tick();
        nicEn = 1'b0; net_si = 1'b0;
        check("rx_ri_after", 64'(net_ri), 64'd1);
        peek(2'b01);
        check("rx_ib_empty", d_out, 64'd0);
        peek(2'b00);
        nicEn = 1'b1;
        tick();
        nicEn = 1'b0;
        check("rx_stale_ib", d_out, 64'h1234);
        peek(2'b01);
        check("rx_stale_no_change", d_out, 64'd0);

        // Write while full is dropped; writes to other addresses are ignored
        net_ro = 1'b0; net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h11;
        tick();
        d_in = 64'h22;
        tick();
        addr = 2'b00; d_in = 64'h99;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        check("drop_do", net_do, 64'h11);
        check("drop_so", 64'(net_so), 64'd0);
        peek(2'b00);
        check("wr_ib_ignored", d_out, 64'h1234);
        net_ro = 1'b1;
        #1;
        check("drop_release_so", 64'(net_so), 64'd1);
        check("drop_release_do", net_do, 64'h11);
        tick();
        peek(2'b11);
        check("drop_ob_empty", d_out, 64'd0);

        // Concurrency: a consume, a transmit and a receive in flight together
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'hABCD;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h33;
        tick();
        net_si = 1'b0; nicWrEn = 1'b0; addr = 2'b00;
        net_ro = 1'b1;
        #1;
        check("conc_so", 64'(net_so), 64'd1);
        check("conc_rd", d_out, 64'hABCD);
        tick();
        nicEn = 1'b0;
        check("conc_ri", 64'(net_ri), 64'd1);
        check("conc_so_clr", 64'(net_so), 64'd0);
        peek(2'b01);
        check("conc_ib_empty", d_out, 64'd0);
        peek(2'b11);
        check("conc_ob_empty", d_out, 64'd0);

        // A write in the same cycle that a transmit drains the buffer is dropped
        net_ro = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h44;
        tick();
        net_ro = 1'b1; d_in = 64'h55;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
        check("race_do", net_do, 64'h44);
        peek(2'b11);
        check("race_ob_empty", d_out, 64'd0);

        // Reset applied between edges, with both buffers full
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'h7777;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h66;
        tick();
        net_si = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b1;
        #1;
        check("prerst_so", 64'(net_so), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_so", 64'(net_so), 64'd0);
        check("midrst_ri", 64'(net_ri), 64'd1);
        check("midrst_do", net_do, 64'd0);
        peek(2'b01);
        check("midrst_ib_sts", d_out, 64'd0);
        peek(2'b11);
        check("midrst_ob_sts", d_out, 64'd0);
        peek(2'b00);
        check("midrst_ib", d_out, 64'd0);
        tick();
        reset = 1'b1;
        #1;
        check("postrst_ri", 64'(net_ri), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of every data port and channel buffer.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 SHALL clear all state immediately, independent of clk.
REQ-004 addr  input  2  processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-005 nicEn  input  1  processor access enable.
REQ-006 nicWrEn  input  1  processor write enable; it is valid only when nicEn=1.
REQ-007 d_in  input  DATA_WIDTH  processor write data.
REQ-008 d_out  output  DATA_WIDTH  processor read data.
REQ-009 net_si  input  1  router-to-NIC send valid.
REQ-010 net_ri  output  1  NIC-to-router ready, meaning the input buffer can accept a packet.
REQ-011 net_di  input  DATA_WIDTH  router-to-NIC packet.
REQ-012 net_so  output  1  NIC-to-router send valid.
REQ-013 net_ro  input  1  router ready to accept a packet.
REQ-014 net_do  output  DATA_WIDTH  NIC-to-router packet.
REQ-015 net_polarity  input  1  current router virtual-channel phase.

Function
REQ-016 State SHALL consist of a one-entry input buffer (ib, ib_full) and a one-entry output buffer (ob, ob_full).
REQ-017 Buffer ordering SHALL be [0:DATA_WIDTH-1], and bit 0 of a packet SHALL be its VC bit.
REQ-018 d_out SHALL be combinational from addr with zero-cycle read latency:
- 00: ib
- 01: {zeros, ib_full} in bit DATA_WIDTH-1
- 11: {zeros, ob_full} in bit DATA_WIDTH-1
- 10: all zeros
REQ-019 Processor write: when nicEn=1, nicWrEn=1, addr=10 and ob_full=0, the block SHALL load ob<=d_in and set ob_full<=1 at the edge.
REQ-020 A processor write while ob_full=1 SHALL be dropped, leaving ob unchanged; software polls addr 11 before writing.
REQ-021 A processor write to addr 00, 01 or 11 SHALL be ignored.
REQ-022 Processor read-consume: when nicEn=1, nicWrEn=0, addr=00 and ib_full=1, the block SHALL clear ib_full at the edge and keep ib unchanged.
REQ-023 A read of addr 00 while ib_full=0 SHALL return the stale ib and change no state.
REQ-024 Reads of addr 01 and 11 SHALL have no side effects.
REQ-025 net_ri SHALL equal ~ib_full combinationally.
REQ-026 When net_si=1 and net_ri=1, the block SHALL capture ib<=net_di and set ib_full<=1 at the edge.
REQ-027 net_si=1 while ib_full=1 SHALL be ignored; the router holds the packet.
REQ-028 net_so SHALL equal ob_full & net_ro & (ob[0]==net_polarity), combinationally.
REQ-029 net_do SHALL equal ob at all times.
REQ-030 When net_so=1 at an edge, ob_full SHALL clear at that edge, giving one packet per handshake.
REQ-031 A packet whose VC bit mismatches net_polarity SHALL be held in ob until the polarity matches.
REQ-032 A processor write issued in the same cycle ob_full clears through transmit SHALL be dropped, because it is qualified by the pre-edge ob_full=1.
REQ-033 A processor read-consume and an incoming packet cannot coincide (net_ri=0 while ib_full=1).
- A consume at edge N SHALL make net_ri=1 from cycle N+1.
REQ-034 Input and output paths SHALL operate concurrently and independently in the same cycle.
REQ-035 nicEn=0 SHALL cause no state change; d_out still follows addr.

Reset
REQ-036 Asserting reset (0) SHALL set ib, ob, ib_full and ob_full to 0 asynchronously, mid-transfer included; any partially handshaken packet is discarded.
REQ-037 While reset=0, outputs SHALL be: net_ri=1, net_so=0, net_do=0, and d_out=0 for every addr.
REQ-038 The first state update after release SHALL occur on the next rising clk with reset=1.

Verification
REQ-039 Reset mid-operation: ob_full=1, ib_full=1, drive reset=0 between edges -> net_so=0 and net_ri=1 immediately; addr 01 and 11 read 0.
REQ-040 Send path: net_polarity=1, net_ro=1, write addr 10 d_in=0x8000_0000_0000_00A5 -> next cycle net_so=1, net_do=0x8000_0000_0000_00A5; after that edge ob_full=0.
REQ-041 Polarity hold: net_polarity=0, write ob with bit0=1 -> net_so=0 for 5 cycles with addr 11 reading 1; toggle net_polarity=1 -> net_so=1 that cycle, cleared at the edge.
REQ-042 Receive path: net_si=1, net_di=0x1234 -> next cycle net_ri=0 and addr 01 reads 1; read addr 00 -> d_out=0x1234 and addr 01 reads 0 in the following cycle; a second net_si is held while full.
REQ-043 Full drop: net_ro=0, write 0x11 then 0x22 to addr 10 -> ob remains 0x11; raise net_ro with polarity matched -> net_do=0x11.
REQ-044 Concurrency: consume ib, write ob and router-accept ob in one cycle -> all three take effect, except the ob write is dropped per REQ-032.
